// File: rtl/cpu_boot_ctrl_pkg.sv
// Shared types and helpers for the cpu boot sequencer.
package cpu_boot_ctrl_pkg;

    localparam int unsigned ADDR_SHIFT = 2;
    localparam int unsigned WCNT_W     = 11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        LOAD_D,
        RELEASE,
        RUN,
        DUMP_RD,
        DUMP_OUT,
        DONE
    } boot_state_e;

    // Clamp a requested word count to the memory depth.
    function automatic logic [WCNT_W-1:0] sat_count(input logic [WCNT_W-1:0] req,
                                                    input int unsigned       depth);
        logic [WCNT_W-1:0] lim;
        lim = WCNT_W'(depth);
        return (req > lim) ? lim : req;
    endfunction

    // Byte address of a word index, upper bits zero.
    function automatic logic [31:0] word_addr(input logic [WCNT_W-1:0] idx);
        return 32'(idx) << ADDR_SHIFT;
    endfunction

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Load stream, dump stream and both cpu external memory ports.
interface cpu_boot_ctrl_if;
    import cpu_boot_ctrl_pkg::*;

    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [31:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [31:0] wdata_ext_2;
    logic [31:0] rdata_ext_2;

    modport master (
        input  s_valid, s_data, m_ready, rdata_ext_2,
        output s_ready, m_valid, m_data,
               addr_ext, wen_ext, ren_ext, wdata_ext,
               addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );

    modport slave (
        output s_valid, s_data, m_ready, rdata_ext_2,
        input  s_ready, m_valid, m_data,
               addr_ext, wen_ext, ren_ext, wdata_ext,
               addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );

endinterface

// File: rtl/boot_word_cnt.sv
// Loadable word index / remaining counter shared by the load and dump phases.
module boot_word_cnt
    import cpu_boot_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [WCNT_W-1:0] count_i,
    input  logic              step_i,
    output logic [WCNT_W-1:0] idx_o,
    output logic              last_o
);

    logic [WCNT_W-1:0] idx_q;
    logic [WCNT_W-1:0] rem_q;

    // Load restarts at index 0; each step advances index and consumes one word.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            rem_q <= '0;
        end else if (load_i) begin
            idx_q <= '0;
            rem_q <= count_i;
        end else if (step_i && (rem_q != '0)) begin
            idx_q <= idx_q + 1'b1;
            rem_q <= rem_q - 1'b1;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (rem_q == WCNT_W'(1));

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot sequencer: load imem/dmem, release and run the cpu, dump dmem.
module cpu_boot_ctrl
    import cpu_boot_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 512,
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [9:0]       imem_words,
    input  logic [10:0]      dmem_words,
    input  logic [10:0]      dump_words,
    input  logic [CNT_W-1:0] run_cycles,
    cpu_boot_ctrl_if.master  bus,
    output logic             cpu_arst_n,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done
);

    boot_state_e       state_q;
    logic [WCNT_W-1:0] dmem_n_q, dump_n_q;
    logic [CNT_W-1:0]  run_n_q, run_cnt_q;
    logic              s_ready_q, m_valid_q, fresh_q;
    logic [31:0]       m_data_q;
    logic              wen_q, wen2_q, ren2_q;
    logic [31:0]       addr_q, wdata_q, addr2_q, wdata2_q;
    logic              arst_n_q, enable_q, done_q;

    logic [WCNT_W-1:0] imem_sat, dmem_sat, dump_sat;
    logic              load_beat, dump_hs;
    logic              cnt_load;
    logic [WCNT_W-1:0] cnt_val;
    logic [WCNT_W-1:0] cnt_idx;
    logic              cnt_last;

    // Saturated counts, handshakes and counter load selection.
    always_comb begin
        imem_sat  = sat_count({1'b0, imem_words}, IMEM_DEPTH);
        dmem_sat  = sat_count(dmem_words, DMEM_DEPTH);
        dump_sat  = sat_count(dump_words, DMEM_DEPTH);
        load_beat = s_ready_q && bus.s_valid;
        dump_hs   = m_valid_q && bus.m_ready;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        case (state_q)
            IDLE: begin
                cnt_load = start;
                cnt_val  = (imem_sat != '0) ? imem_sat : dmem_sat;
            end
            LOAD_I: begin
                cnt_load = load_beat && cnt_last;
                cnt_val  = dmem_n_q;
            end
            RELEASE: begin
                cnt_load = 1'b1;
                cnt_val  = dump_n_q;
            end
            default: ;
        endcase
    end

    boot_word_cnt u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load_i  (cnt_load),
        .count_i (cnt_val),
        .step_i  (load_beat || dump_hs),
        .idx_o   (cnt_idx),
        .last_o  (cnt_last)
    );

    // Sequencer FSM with registered strobes; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dmem_n_q  <= '0;
            dump_n_q  <= '0;
            run_n_q   <= '0;
            run_cnt_q <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            fresh_q   <= 1'b0;
            m_data_q  <= '0;
            wen_q     <= 1'b0;
            wen2_q    <= 1'b0;
            ren2_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            addr2_q   <= '0;
            wdata2_q  <= '0;
            arst_n_q  <= 1'b0;
            enable_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wen_q    <= 1'b0;
            wen2_q   <= 1'b0;
            ren2_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            addr2_q  <= '0;
            wdata2_q <= '0;
            done_q   <= 1'b0;
            fresh_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dmem_n_q <= dmem_sat;
                        dump_n_q <= dump_sat;
                        run_n_q  <= run_cycles;
                        if (imem_sat != '0) begin
                            state_q   <= LOAD_I;
                            s_ready_q <= 1'b1;
                            arst_n_q  <= 1'b0;
                        end else if (dmem_sat != '0) begin
                            state_q   <= LOAD_D;
                            s_ready_q <= 1'b1;
                            arst_n_q  <= 1'b0;
                        end else begin
                            state_q  <= RELEASE;
                            arst_n_q <= 1'b1;
                        end
                    end
                end
                LOAD_I: begin
                    if (load_beat) begin
                        wen_q   <= 1'b1;
                        addr_q  <= word_addr(cnt_idx);
                        wdata_q <= bus.s_data;
                        if (cnt_last) begin
                            if (dmem_n_q != '0) begin
                                state_q <= LOAD_D;
                            end else begin
                                state_q   <= RELEASE;
                                s_ready_q <= 1'b0;
                                arst_n_q  <= 1'b1;
                            end
                        end
                    end
                end
                LOAD_D: begin
                    if (load_beat) begin
                        wen2_q   <= 1'b1;
                        addr2_q  <= word_addr(cnt_idx);
                        wdata2_q <= bus.s_data;
                        if (cnt_last) begin
                            state_q   <= RELEASE;
                            s_ready_q <= 1'b0;
                            arst_n_q  <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (run_n_q != '0) begin
                        state_q   <= RUN;
                        enable_q  <= 1'b1;
                        run_cnt_q <= run_n_q;
                    end else if (dump_n_q != '0) begin
                        state_q <= DUMP_RD;
                        ren2_q  <= 1'b1;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                RUN: begin
                    run_cnt_q <= run_cnt_q - 1'b1;
                    if (run_cnt_q == CNT_W'(1)) begin
                        enable_q <= 1'b0;
                        if (dump_n_q != '0) begin
                            state_q <= DUMP_RD;
                            ren2_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DUMP_RD: begin
                    state_q   <= DUMP_OUT;
                    m_valid_q <= 1'b1;
                    fresh_q   <= 1'b1;
                end
                DUMP_OUT: begin
                    if (fresh_q) begin
                        m_data_q <= bus.rdata_ext_2;
                    end
                    if (dump_hs) begin
                        m_valid_q <= 1'b0;
                        if (cnt_last) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DUMP_RD;
                            ren2_q  <= 1'b1;
                            addr2_q <= word_addr(cnt_idx + 1'b1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // First DUMP_OUT cycle passes read data straight through so a word can
    // leave every two cycles; afterwards the captured copy holds it stable.
    assign bus.m_data      = fresh_q ? bus.rdata_ext_2 : m_data_q;
    assign bus.m_valid     = m_valid_q;
    assign bus.s_ready     = s_ready_q;
    assign bus.addr_ext    = addr_q;
    assign bus.wen_ext     = wen_q;
    assign bus.ren_ext     = 1'b0;
    assign bus.wdata_ext   = wdata_q;
    assign bus.addr_ext_2  = addr2_q;
    assign bus.wen_ext_2   = wen2_q;
    assign bus.ren_ext_2   = ren2_q;
    assign bus.wdata_ext_2 = wdata2_q;
    assign cpu_arst_n      = arst_n_q;
    assign cpu_enable      = enable_q;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Self-checking bench for cpu_boot_ctrl against a transaction-level model.
module tb_cpu_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  imem_words;
    logic [10:0] dmem_words;
    logic [10:0] dump_words;
    logic [31:0] run_cycles;
    logic        cpu_arst_n, cpu_enable, busy, done;

    always #5 clk = ~clk;

    cpu_boot_ctrl_if bif ();

    cpu_boot_ctrl #(
        .IMEM_DEPTH (512),
        .DMEM_DEPTH (1024),
        .CNT_W      (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_words (imem_words),
        .dmem_words (dmem_words),
        .dump_words (dump_words),
        .run_cycles (run_cycles),
        .bus        (bif),
        .cpu_arst_n (cpu_arst_n),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .done       (done)
    );

    // Data memory behind the *_2 port, synchronous read.
    logic [31:0] dmem_env [0:1023];
    always @(posedge clk) begin
        if (bif.wen_ext_2) dmem_env[bif.addr_ext_2[11:2]] <= bif.wdata_ext_2;
        if (bif.ren_ext_2) bif.rdata_ext_2 <= dmem_env[bif.addr_ext_2[11:2]];
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference dmem contents, as the loads should have left them.
    logic [31:0] ref_dmem [0:1023];
    int          dmem_hi = 0;

    logic [31:0] stream [$];
    logic [63:0] iw_log [$];
    logic [63:0] dw_log [$];
    logic [31:0] dump_log [$];
    int cyc = 0, start_cyc, rel_cyc, en_cnt, en_first, en_last, done_cnt, done_cyc, sptr;
    logic        pv_hold = 1'b0;
    logic [31:0] pv_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observe one clock cycle with the inputs currently applied, then advance.
    task automatic cycle();
        chk("port_excl", {63'b0, cpu_enable && (bif.wen_ext || bif.wen_ext_2 || bif.ren_ext_2)}, 64'd0);
        if (pv_hold) begin
            chk("m_valid_hold", {63'b0, bif.m_valid}, 64'd1);
            chk("m_data_hold", {32'b0, bif.m_data}, {32'b0, pv_data});
        end
        pv_hold = bif.m_valid && !bif.m_ready;
        pv_data = bif.m_data;
        if (bif.wen_ext)   iw_log.push_back({bif.addr_ext, bif.wdata_ext});
        if (bif.wen_ext_2) dw_log.push_back({bif.addr_ext_2, bif.wdata_ext_2});
        if (cpu_enable) begin
            if (en_cnt == 0) en_first = cyc;
            en_last = cyc;
            en_cnt++;
        end
        if (cpu_arst_n && rel_cyc < 0 && cyc > start_cyc) rel_cyc = cyc;
        if (bif.m_valid && bif.m_ready) dump_log.push_back(bif.m_data);
        if (bif.s_valid && bif.s_ready) sptr++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    // One full boot sequence; svm: 0 continuous, 1 toggling, 2 random s_valid;
    // mrm: 0 always ready, 1 random, 2 ready after 4 stalled cycles per word.
    task automatic run_seq(input string nm, input int iw, input int dw, input int uw,
                           input int rc, input int svm, input int mrm,
                           input bit ideal, input bit poke);
        int ni, nd, nu, mr_wait;
        bit poked;
        ni = (iw > 512) ? 512 : iw;
        nd = (dw > 1024) ? 1024 : dw;
        nu = (uw > 1024) ? 1024 : uw;
        while (stream.size() < ni + nd) stream.push_back($urandom());
        iw_log.delete(); dw_log.delete(); dump_log.delete();
        start_cyc = cyc; rel_cyc = -1; en_cnt = 0; done_cnt = 0; sptr = 0;
        en_first = 0; en_last = -1; done_cyc = 0; mr_wait = 0; poked = 1'b0;

        imem_words = 10'(iw); dmem_words = 11'(dw); dump_words = 11'(uw); run_cycles = 32'(rc);
        start = 1'b1; bif.s_valid = 1'b0; bif.m_ready = 1'b0;
        cycle();
        start = 1'b0;
        imem_words = 10'($urandom_range(1, 9)); dmem_words = 11'($urandom_range(1, 9));
        dump_words = 11'($urandom_range(1, 9)); run_cycles = 32'($urandom_range(1, 9));

        for (int k = 0; k < 20000 && done_cnt == 0; k++) begin
            case (svm)
                0:       bif.s_valid = 1'b1;
                1:       bif.s_valid = (k % 2 == 0);
                default: bif.s_valid = 1'($urandom_range(0, 1));
            endcase
            bif.s_data = (sptr < stream.size()) ? stream[sptr] : $urandom();
            case (mrm)
                0:       bif.m_ready = 1'b1;
                1:       bif.m_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bif.m_valid) begin
                        bif.m_ready = (mr_wait >= 4);
                        mr_wait++;
                    end else begin
                        bif.m_ready = 1'b0;
                        mr_wait = 0;
                    end
                end
            endcase
            if (poke && !poked && cpu_enable) begin
                start = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            cycle();
        end
        start = 1'b0; bif.s_valid = 1'b0; bif.m_ready = 1'b0;

        chk({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({nm, "_idle_after"}, {62'b0, busy, done}, 64'd0);

        chk({nm, "_imem_n"}, 64'(iw_log.size()), 64'(ni));
        for (int i = 0; i < iw_log.size() && i < ni; i++)
            chk({nm, "_imem_wr"}, iw_log[i], {32'(i * 4), stream[i]});

        for (int i = 0; i < nd; i++) ref_dmem[i] = stream[ni + i];
        if (nd > dmem_hi) dmem_hi = nd;
        chk({nm, "_dmem_n"}, 64'(dw_log.size()), 64'(nd));
        for (int i = 0; i < dw_log.size() && i < nd; i++)
            chk({nm, "_dmem_wr"}, dw_log[i], {32'(i * 4), stream[ni + i]});

        chk({nm, "_en_cycles"}, 64'(en_cnt), 64'(rc));
        if (rc > 0) begin
            chk({nm, "_en_contig"}, 64'(en_last - en_first + 1), 64'(rc));
            chk({nm, "_release_gap"}, 64'(en_first - rel_cyc), 64'd1);
        end

        chk({nm, "_dump_n"}, 64'(dump_log.size()), 64'(nu));
        for (int i = 0; i < dump_log.size() && i < nu; i++)
            chk({nm, "_dump_data"}, {32'b0, dump_log[i]}, {32'b0, ref_dmem[i]});

        if (ideal) begin
            chk({nm, "_release_at"}, 64'(rel_cyc - start_cyc), 64'(1 + ni + nd));
            chk({nm, "_done_at"}, 64'(done_cyc - start_cyc), 64'(2 + ni + nd + rc + 2 * nu));
        end
    endtask

    initial begin
        int iw, dw, uw, rc, svm, mrm;
        rst = 1'b1; start = 1'b0;
        imem_words = '0; dmem_words = '0; dump_words = '0; run_cycles = '0;
        bif.s_valid = 1'b0; bif.s_data = '0; bif.m_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_arst_n", {63'b0, cpu_arst_n}, 64'd0);
        chk("rst_flags", {58'b0, cpu_enable, busy, done, bif.s_ready, bif.m_valid, bif.wen_ext}, 64'd0);
        chk("rst_strobes", {62'b0, bif.wen_ext_2, bif.ren_ext_2}, 64'd0);
        chk("rst_addr", {bif.addr_ext, bif.addr_ext_2}, 64'd0);
        chk("rst_m_data", {32'b0, bif.m_data}, 64'd0);
        rst = 1'b0;
        cycle();

        // Program load and run
        stream.delete();
        stream.push_back(32'h20010005); stream.push_back(32'h20020007); stream.push_back(32'h00221820);
        run_seq("t1", 3, 0, 0, 5, 0, 0, 1'b1, 1'b0);

        // Data load with gappy stream
        stream.delete();
        stream.push_back(32'hAAAA0000); stream.push_back(32'h5555FFFF);
        run_seq("t2", 0, 2, 0, 3, 1, 0, 1'b0, 1'b0);

        // Dump with back-pressure
        stream.delete();
        run_seq("t3", 0, 0, 2, 0, 0, 2, 1'b0, 1'b0);

        // Empty sequence
        stream.delete();
        run_seq("t4", 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);

        // Reset in the middle of an instruction load
        imem_words = 10'd3; start = 1'b1; bif.s_valid = 1'b0;
        cycle();
        start = 1'b0;
        chk("t5_s_ready", {63'b0, bif.s_ready}, 64'd1);
        bif.s_valid = 1'b1; bif.s_data = 32'h11112222;
        cycle();
        chk("t5_beat1", {31'b0, bif.wen_ext, bif.addr_ext}, {31'b0, 1'b1, 32'h0});
        bif.s_data = 32'h33334444; rst = 1'b1;
        cycle();
        rst = 1'b0; bif.s_valid = 1'b0;
        chk("t5_after_rst", {59'b0, busy, bif.s_ready, bif.wen_ext, cpu_enable, bif.m_valid}, 64'd0);
        chk("t5_arst_n", {63'b0, cpu_arst_n}, 64'd0);
        chk("t5_wr_bus", {bif.addr_ext, bif.wdata_ext}, 64'd0);
        stream.delete();
        run_seq("t5", 3, 0, 0, 2, 2, 0, 1'b0, 1'b0);

        // Saturated instruction load, start pulsed while running
        stream.delete();
        run_seq("t6", 600, 0, 0, 12, 0, 0, 1'b1, 1'b1);

        // Random sequences
        for (int r = 0; r < 4; r++) begin
            stream.delete();
            iw  = $urandom_range(0, 20);
            dw  = $urandom_range(0, 20);
            uw  = $urandom_range(0, dmem_hi);
            rc  = $urandom_range(0, 15);
            svm = $urandom_range(0, 2);
            mrm = $urandom_range(0, 1);
            run_seq("rnd", iw, dw, uw, rc, svm, mrm, (svm == 0 && mrm == 0), 1'b0);
        end

        // Saturated data load and dump
        stream.delete();
        run_seq("t7", 0, 1500, 2000, 1, 2, 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
